// File: rtl/gpi_pkg.sv
// Shared constants for the general-purpose input peripheral: register
// offsets, default window base and CPU data width.
package gpi_pkg;

  localparam int         DATA_W        = 32;
  localparam logic [9:0] GPI_BASE_ADDR = 10'h3F0;

  typedef enum logic [1:0] {
    GPI_LEVEL = 2'd0,
    GPI_EDGE  = 2'd1,
    GPI_MASK  = 2'd2,
    GPI_RSVD  = 2'd3
  } gpi_reg_e;

endpackage

// File: rtl/gpi_periph_if.sv
// CPU data-port view of the GPI register window: the CPU (master) drives
// address/data/strobes, the peripheral (slave) returns registered read data.
interface gpi_periph_if;
  import gpi_pkg::*;

  logic [9:0]        address;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        width;
  logic              write;
  logic [DATA_W-1:0] data_out;

  modport master (output address, data_in, width, write, input  data_out);
  modport slave  (input  address, data_in, width, write, output data_out);

endinterface

// File: rtl/gpi_debounce.sv
// One input pin: two-flop synchroniser, stability counter and accepted level,
// plus a combinational pulse in the cycle whose edge raises the level.
module gpi_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_d = level;
    cnt_d   = '0;
    if (sync != level) begin
      if (cnt == CNT_LAST) level_d = sync;
      else                 cnt_d   = cnt + CNT_W'(1);
    end
  end

  assign rise = level_d & ~level;

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta  <= pin;
      sync  <= meta;
      cnt   <= cnt_d;
      level <= level_d;
    end
  end

endmodule

// File: rtl/gpi_periph.sv
// Memory-mapped GPI peripheral: debounced pin levels, sticky rising-edge
// flags (write-1-to-clear), an interrupt mask and a registered read port.
module gpi_periph
  import gpi_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR       = GPI_BASE_ADDR,
  parameter int         N_PINS          = 8,
  parameter int         DEBOUNCE_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_PINS-1:0] pins,
  gpi_periph_if.slave       bus,
  output logic              irq
);

  logic [N_PINS-1:0] level;
  logic [N_PINS-1:0] rise;
  logic [N_PINS-1:0] edge_flags;
  logic [N_PINS-1:0] edge_flags_next;
  logic [N_PINS-1:0] mask;
  logic [N_PINS-1:0] mask_next;
  logic [DATA_W-1:0] rd_data;
  logic              sel;
  logic              wen;
  gpi_reg_e          reg_sel;
  logic              unused_bits;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pins[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  assign sel     = (bus.address[9:4] == BASE_ADDR[9:4]);
  assign reg_sel = gpi_reg_e'(bus.address[3:2]);
  assign wen     = bus.write && sel && bus.width[0];

  // Rise is OR-ed in after the clear, so a same-cycle W1C cannot lose an edge.
  always_comb begin
    edge_flags_next = edge_flags | rise;
    mask_next       = mask;
    if (wen && reg_sel == GPI_EDGE)
      edge_flags_next = (edge_flags & ~bus.data_in[N_PINS-1:0]) | rise;
    if (wen && reg_sel == GPI_MASK)
      mask_next = bus.data_in[N_PINS-1:0];
  end

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (reg_sel)
        GPI_LEVEL: rd_data = DATA_W'(level);
        GPI_EDGE:  rd_data = DATA_W'(edge_flags);
        GPI_MASK:  rd_data = DATA_W'(mask);
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_flags   <= '0;
      mask         <= '0;
      bus.data_out <= '0;
      irq          <= 1'b0;
    end else begin
      edge_flags   <= edge_flags_next;
      mask         <= mask_next;
      bus.data_out <= rd_data;
      irq          <= |(edge_flags_next & mask_next);
    end
  end

  assign unused_bits = ^{bus.address[1:0], bus.data_in[DATA_W-1:N_PINS], bus.width[3:1]};

endmodule

// File: tb/tb_gpi_periph.sv
// Scoreboard bench for gpi_periph: the driver steps a window-based reference
// model and queues expected read data/irq; the monitor compares every cycle.
module tb_gpi_periph;
  import gpi_pkg::*;

  localparam int         N    = 8;
  localparam int         D    = 4;
  localparam logic [9:0] BASE = 10'h3F0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pins;
  logic         irq;

  gpi_periph_if bus ();

  gpi_periph #(.BASE_ADDR(BASE), .N_PINS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  // Reference state: accepted levels, flags, mask, a two-deep pin delay line
  // and the window of the last D synchronised samples.
  logic [N-1:0] m_level, m_flags, m_mask;
  logic [N-1:0] pin_dly[$];
  logic [N-1:0] sync_win[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_flags = '0;
    m_mask  = '0;
    pin_dly.delete();
    repeat (2) pin_dly.push_back('0);
    sync_win.delete();
    repeat (D) sync_win.push_back('0);
  endtask

  // Effect of one rising edge with the given bus/pin inputs.
  task automatic model_step(input logic [N-1:0] p, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] w,
                            input logic wr, output exp_t e);
    logic         sel, wen;
    logic [N-1:0] sync, new_level, rise;
    logic         stable;
    sel  = (a[9:4] == BASE[9:4]);
    e.rd = 32'h0;
    if (sel) begin
      case (a[3:2])
        2'd0:    e.rd = 32'(m_level);
        2'd1:    e.rd = 32'(m_flags);
        2'd2:    e.rd = 32'(m_mask);
        default: e.rd = 32'h0;
      endcase
    end
    sync = pin_dly.pop_front();
    pin_dly.push_back(p);
    sync_win.push_back(sync);
    void'(sync_win.pop_front());
    // A pin's level flips once D consecutive synchronised samples disagree with it.
    new_level = m_level;
    for (int i = 0; i < N; i++) begin
      stable = 1'b1;
      foreach (sync_win[j]) if (sync_win[j][i] != sync[i]) stable = 1'b0;
      if (stable && sync[i] != m_level[i]) new_level[i] = sync[i];
    end
    rise    = new_level & ~m_level;
    m_level = new_level;
    wen     = wr && sel && w[0];
    if (wen && a[3:2] == 2'd1) m_flags = m_flags & ~d[N-1:0];
    m_flags = m_flags | rise;
    if (wen && a[3:2] == 2'd2) m_mask = d[N-1:0];
    e.irq = |(m_flags & m_mask);
  endtask

  // Drive one cycle at the current negedge, queue its expectation, then
  // advance to the next negedge.
  task automatic cyc(input logic [N-1:0] p, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] w, input logic wr);
    exp_t e;
    pins        = p;
    bus.address = a;
    bus.data_in = d;
    bus.width   = w;
    bus.write   = wr;
    model_step(p, a, d, w, wr, e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rd(input logic [N-1:0] p, input logic [3:0] off);
    cyc(p, BASE | 10'(off), 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wrr(input logic [N-1:0] p, input logic [3:0] off,
                     input logic [31:0] d, input logic [3:0] w);
    cyc(p, BASE | 10'(off), d, w, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("data_out@%0d", cyc_n), bus.data_out, e.rd);
        check($sformatf("irq@%0d", cyc_n), 32'(irq), 32'(e.irq));
      end
    end
  end

  initial begin : driver
    logic [N-1:0] cur;
    logic [9:0]   a;
    rst_n       = 1'b0;
    pins        = 8'hFF;
    bus.address = 10'h0;
    bus.data_in = 32'h0;
    bus.width   = 4'h0;
    bus.write   = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    check("reset_data_out", bus.data_out, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;

    // Pins held high through reset: LEVEL visible one cycle after edge 6.
    repeat (6) rd(8'hFF, 4'h0);
    check("level_edge6", bus.data_out, 32'h0);
    rd(8'hFF, 4'h0);
    check("level_edge7", bus.data_out, 32'h000000FF);

    // Release all pins, flags remain sticky, then clear them.
    repeat (8) rd(8'h00, 4'h4);
    check("edge_sticky", bus.data_out, 32'h000000FF);
    wrr(8'h00, 4'h4, 32'hFF, 4'hF);
    repeat (2) rd(8'h00, 4'h4);
    check("edge_w1c", bus.data_out, 32'h0);

    // Single step on pin 0 with the mask still clear.
    repeat (8) rd(8'h01, 4'h0);
    repeat (2) rd(8'h01, 4'h4);
    check("edge_pin0", bus.data_out, 32'h1);
    check("irq_masked", 32'(irq), 32'h0);

    // Three-cycle glitch on pin 3 must not be accepted.
    repeat (3) rd(8'h09, 4'h4);
    repeat (6) rd(8'h01, 4'h4);
    check("glitch", bus.data_out, 32'h1);

    // Masked rise on pin 3 raises irq; W1C drops it.
    wrr(8'h01, 4'h8, 32'h08, 4'h1);
    repeat (8) rd(8'h09, 4'h4);
    check("edge_pin3", bus.data_out, 32'h9);
    check("irq_set", 32'(irq), 32'h1);
    wrr(8'h09, 4'h4, 32'h08, 4'h1);
    repeat (2) rd(8'h09, 4'h4);
    check("edge_cleared", bus.data_out, 32'h1);
    check("irq_cleared", 32'(irq), 32'h0);

    // W1C of bit 2 on the very edge its rise arrives: set wins.
    repeat (5) rd(8'h0D, 4'h4);
    wrr(8'h0D, 4'h4, 32'h04, 4'h1);
    repeat (2) rd(8'h0D, 4'h4);
    check("set_wins", bus.data_out, 32'h5);

    // Lane and decode rules.
    wrr(8'h0D, 4'h8, 32'hFF, 4'b0010);
    wrr(8'h0D, 4'h0, 32'h0, 4'hF);
    repeat (2) rd(8'h0D, 4'h8);
    check("mask_lane", bus.data_out, 32'h08);
    cyc(8'h0D, 10'h200, 32'h0, 4'h0, 1'b0);
    cyc(8'h0D, 10'h200, 32'h0, 4'h0, 1'b0);
    check("outside_window", bus.data_out, 32'h0);

    // Randomised traffic against the reference model.
    cur = 8'h0D;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) cur = cur ^ (8'h1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 9) < 8)
        a = {BASE[9:4], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else
        a = 10'($urandom);
      cyc(cur, a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of a debounce count.
    wrr(cur, 4'h8, 32'hFF, 4'h1);
    rd(~cur, 4'h8);
    rd(~cur, 4'h8);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_data_out", bus.data_out, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) rd(8'h00, 4'((i % 3) * 4));

    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
